// File: rtl/handshake_constant_seq_pkg.sv
// Shared types and helpers for the handshake constant/sequence source.
package handshake_constant_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } hs_state_e;

  // Beat index width: max(1, clog2(repeat)).
  function automatic int unsigned idx_width(input int unsigned repeat_cnt);
    int unsigned w;
    w = $clog2(repeat_cnt);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/handshake_constant_seq.sv
// Emits REPEAT beats of CONST_VALUE + k*STEP for every accepted ctrl token,
// with back-to-back token acceptance on the final beat.
module handshake_constant_seq
  import handshake_constant_seq_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] CONST_VALUE = DATA_WIDTH'(32'h0000_0CA2),
  parameter logic [DATA_WIDTH-1:0] STEP        = '0,
  parameter int unsigned           REPEAT      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int unsigned IDX_W = idx_width(REPEAT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REPEAT - 1);

  if (REPEAT < 1 || REPEAT > 65535) begin : g_bad_repeat
    $error("handshake_constant_seq: REPEAT must be in 1..65535");
  end

  hs_state_e             state_q, state_nxt;
  logic [IDX_W-1:0]      idx_q, idx_nxt;
  logic [DATA_WIDTH-1:0] outs_q, outs_nxt;
  logic                  last_beat;

  assign last_beat  = (idx_q == LAST_IDX);
  assign outs_valid = (state_q == EMIT);
  assign ctrl_ready = (state_q == IDLE) || (last_beat && outs_ready);
  assign outs       = outs_q;

  // Synchronous reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      outs_q  <= CONST_VALUE;
    end else begin
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
      outs_q  <= outs_nxt;
    end
  end

  // Next-state: start, advance, restart on final beat, or return to idle.
  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    outs_nxt  = outs_q;
    unique case (state_q)
      IDLE: begin
        if (ctrl_valid) begin
          state_nxt = EMIT;
          idx_nxt   = '0;
          outs_nxt  = CONST_VALUE;
        end
      end
      EMIT: begin
        if (outs_ready) begin
          if (!last_beat) begin
            idx_nxt  = idx_q + IDX_W'(1);
            outs_nxt = outs_q + STEP;
          end else if (ctrl_valid) begin
            idx_nxt  = '0;
            outs_nxt = CONST_VALUE;
          end else begin
            state_nxt = IDLE;
            idx_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Randomized bench: three configurations checked against a queue-of-expected-beats model.
module tb_handshake_constant_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cv   [3];
  logic        ordy [3];
  logic        ov   [3];
  logic        cr   [3];
  logic [31:0] o0, o2;
  logic [7:0]  o1;
  logic [31:0] ow   [3];

  always_comb begin
    ow[0] = o0;
    ow[1] = {24'h0, o1};
    ow[2] = o2;
  end

  handshake_constant_seq u0 (
    .clk(clk), .rst(rst), .ctrl_valid(cv[0]), .ctrl_ready(cr[0]),
    .outs(o0), .outs_valid(ov[0]), .outs_ready(ordy[0])
  );

  handshake_constant_seq #(
    .DATA_WIDTH(8), .CONST_VALUE(8'hFE), .STEP(8'h01), .REPEAT(4)
  ) u1 (
    .clk(clk), .rst(rst), .ctrl_valid(cv[1]), .ctrl_ready(cr[1]),
    .outs(o1), .outs_valid(ov[1]), .outs_ready(ordy[1])
  );

  handshake_constant_seq #(
    .DATA_WIDTH(32), .CONST_VALUE(32'd10), .STEP(32'd2), .REPEAT(3)
  ) u2 (
    .clk(clk), .rst(rst), .ctrl_valid(cv[2]), .ctrl_ready(cr[2]),
    .outs(o2), .outs_valid(ov[2]), .outs_ready(ordy[2])
  );

  // Per-instance configuration seen by the model.
  int unsigned rep [3] = '{1, 4, 3};
  logic [31:0] cst [3] = '{32'h0000_0CA2, 32'h0000_00FE, 32'd10};
  logic [31:0] stp [3] = '{32'd0, 32'd1, 32'd2};
  logic [31:0] msk [3] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_FFFF};

  logic [31:0] q [3][$];
  logic [31:0] last_out [3] = '{32'h0000_0CA2, 32'h0000_00FE, 32'd10};
  logic [31:0] log1 [$];
  int          tok   [3] = '{0, 0, 0};
  int          beats [3] = '{0, 0, 0};
  int          n_checks = 0;
  int          n_errors = 0;
  bit          chk_en = 1'b0;
  bit          log_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: outstanding beats of accepted tokens sit in a queue; the front is on outs.
  task automatic model_step(input int i);
    int          sz;
    logic        ev, er;
    logic [31:0] eo;
    sz = q[i].size();
    ev = (sz > 0);
    er = (sz == 0) || (sz == 1 && ordy[i]);
    eo = ev ? q[i][0] : last_out[i];
    check($sformatf("u%0d outs_valid", i), 32'(ov[i]), 32'(ev));
    check($sformatf("u%0d ctrl_ready", i), 32'(cr[i]), 32'(er));
    check($sformatf("u%0d outs", i), ow[i], eo);
    if (ov[i] && ordy[i]) beats[i]++;
    if (cv[i] && cr[i]) tok[i]++;
    if (log_en && i == 1 && ov[1] && ordy[1]) log1.push_back(ow[1]);
    if (rst) begin
      q[i].delete();
      last_out[i] = cst[i];
    end else begin
      if (ev && ordy[i]) last_out[i] = q[i].pop_front();
      if (er && cv[i])
        for (int k = 0; k < int'(rep[i]); k++)
          q[i].push_back((cst[i] + 32'(k) * stp[i]) & msk[i]);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en)
      for (int i = 0; i < 3; i++) model_step(i);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic r);
    for (int i = 0; i < 3; i++) begin
      cv[i]   = v;
      ordy[i] = r;
    end
  endtask

  task automatic drain();
    bit busy;
    drive(1'b0, 1'b1);
    busy = 1'b1;
    for (int n = 0; n < 40 && busy; n++) begin
      tick();
      busy = ov[0] || ov[1] || ov[2];
    end
    check("drain to idle", 32'(busy), 32'd0);
  endtask

  logic [31:0] exp4 [4] = '{32'hFE, 32'hFF, 32'h00, 32'h01};
  bit          pat  [8] = '{1, 0, 0, 1, 1, 1, 1, 1};

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0);
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // One token into every instance with a always-ready consumer.
    log_en = 1'b1;
    drive(1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b1);
    repeat (8) tick();
    log_en = 1'b0;
    check("u1 first seq beat count", 32'(log1.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      check($sformatf("u1 first seq beat %0d", k),
            (k < log1.size()) ? log1[k] : 32'hDEAD_BEEF, exp4[k]);

    // Tokens held continuously: back-to-back sequences.
    drive(1'b1, 1'b1);
    repeat (18) tick();
    drive(1'b0, 1'b1);
    repeat (6) tick();

    // Consumer stalls in the middle of a sequence.
    drive(1'b1, 1'b1);
    tick();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, pat[k]);
      tick();
    end
    drain();

    // Reset after the second beat, with a token offered in the same cycle.
    drive(1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b1);
    repeat (2) tick();
    drive(1'b1, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b1);
    tick();
    drain();

    // ctrl_valid held with a random consumer: one token per sequence.
    for (int i = 0; i < 3; i++) begin
      tok[i]   = 0;
      beats[i] = 0;
    end
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 3; i++) begin
        cv[i]   = 1'b1;
        ordy[i] = 1'($urandom_range(0, 1));
      end
      tick();
    end
    drain();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d tokens seen", i), 32'(tok[i] > 0), 32'd1);
      check($sformatf("u%0d beats per token", i), 32'(beats[i]), 32'(tok[i] * int'(rep[i])));
    end

    // Fully random traffic including occasional resets.
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < 3; i++) begin
        cv[i]   = 1'($urandom_range(0, 1));
        ordy[i] = 1'($urandom_range(0, 3) != 0);
      end
      tick();
    end
    rst = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/handshake_constant_seq.md
HANDSHAKE_CONSTANT_SEQ -- requirements
Module: handshake_constant_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of outs.
REQ-002 Parameter CONST_VALUE, default 32'h0000_0CA2: first emitted value, truncated to DATA_WIDTH LSBs.
REQ-003 Parameter STEP, default 0: increment added per emitted beat, truncated to DATA_WIDTH; 0 gives a pure constant.
REQ-004 Parameter REPEAT, default 1: output beats per accepted ctrl token; legal range 1..65535.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 ctrl_valid  input  1  control token offered.
REQ-008 ctrl_ready  output  1  control token accepted when high together with ctrl_valid.
REQ-009 outs  output  DATA_WIDTH  emitted value, driven from a register.
REQ-010 outs_valid  output  1  outs holds a valid beat.
REQ-011 outs_ready  input  1  consumer accepts beat when high together with outs_valid.

Function
REQ-012 Two states SHALL exist: IDLE (no beat pending) and EMIT (beat pending on outs).
REQ-013 In IDLE: outs_valid=0, ctrl_ready=1.
REQ-014 In EMIT: outs_valid=1; ctrl_ready = (beat index == REPEAT-1) AND outs_ready; this is the only combinational path from input to output.
REQ-015 IDLE with ctrl_valid=1 -> EMIT next cycle, beat index=0, outs=CONST_VALUE; latency from ctrl handshake to outs_valid is exactly 1 cycle.
REQ-016 EMIT with outs_ready=0: state, index and outs SHALL hold unchanged (no change while valid and not ready).
REQ-017 EMIT with outs_ready=1 and index < REPEAT-1: index+1, outs = outs + STEP modulo 2^DATA_WIDTH, stay in EMIT.
REQ-018 EMIT with outs_ready=1, index = REPEAT-1, ctrl_valid=1: new token accepted same cycle; stay in EMIT, index=0, outs=CONST_VALUE (back-to-back, no bubble).
REQ-019 EMIT with outs_ready=1, index = REPEAT-1, ctrl_valid=0: -> IDLE; outs holds last value.
REQ-020 Sustained throughput SHALL be one beat per cycle while outs_ready=1 and tokens are available.
REQ-021 Addition SHALL wrap silently; no overflow flag.
REQ-022 Beat index width SHALL be max(1, clog2(REPEAT)); index never exceeds REPEAT-1.
REQ-023 REPEAT=1, STEP=0 SHALL behave as a registered constant source: every ctrl token gives exactly one beat of CONST_VALUE.
REQ-024 ctrl_valid during EMIT before the last beat SHALL NOT be accepted (ctrl_ready=0) and SHALL NOT disturb the sequence.

Reset
REQ-025 While rst=1 at a clock edge: state=IDLE, index=0, outs=CONST_VALUE; hence outs_valid=0 and ctrl_ready=1 the cycle after.
REQ-026 rst asserted mid-sequence SHALL abandon remaining beats; no beat of the aborted sequence appears after reset.
REQ-027 rst SHALL take priority over every handshake in the same cycle.

Structure
REQ-028 State encoding (IDLE, EMIT) SHALL be defined as a typedef in the shared handshake package; the constants live as module parameters.
REQ-029 No sub-module required; a single always block for state/index/outs plus continuous assigns for outs_valid/ctrl_ready.
REQ-030 Illegal REPEAT (0 or >65535) SHALL fail elaboration.

Verification
REQ-031 Defaults, one ctrl token, outs_ready=1 -> one beat outs=0x00000CA2 one cycle after the handshake, then IDLE.
REQ-032 DATA_WIDTH=8, CONST_VALUE=8'hFE, STEP=1, REPEAT=4, outs_ready=1 -> beats FE, FF, 00, 01; ctrl_ready high only on the final beat cycle and in IDLE.
REQ-033 REPEAT=3, STEP=2, CONST_VALUE=10, ctrl_valid held high, outs_ready=1 -> continuous 10,12,14,10,12,14 with no gap cycle.
REQ-034 REPEAT=3, outs_ready toggling 1,0,0,1,1 -> beats 10,12,14 each held stable while outs_ready=0; no beat duplicated or lost.
REQ-035 REPEAT=4, rst pulsed after second beat -> outs_valid=0 next cycle, ctrl_ready=1; next token restarts at CONST_VALUE.
REQ-036 ctrl_valid=1 throughout a REPEAT=4 sequence -> exactly one token accepted per sequence, counted by scoreboard equal to beats/4.
